hazard_ctrl_p: RTL and testbench
================================

Name: hazard_ctrl_p

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It generates the stall, flush and forwarding controls for the F/D/E/M/W pipeline registers. It sequences a data-memory wait handshake that freezes the pipeline while memory is not ready. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_WIDTH, 32, width of the stall_cnt and flush_cnt performance counters.
- TIMEOUT, 256, number of consecutive MEM_WAIT cycles that sets mem_timeout.
- ADDR_W, 5, register-index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_d  in  ADDR_W  source register 1 of the instruction in Decode.
- rs2_d  in  ADDR_W  source register 2 of the instruction in Decode.
- rs1_e  in  ADDR_W  source register 1 of the instruction in Execute.
- rs2_e  in  ADDR_W  source register 2 of the instruction in Execute.
- rd_e  in  ADDR_W  destination register in Execute.
- rd_m  in  ADDR_W  destination register in Memory.
- rd_w  in  ADDR_W  destination register in Writeback.
- result_src_e  in  2  result select in Execute; 01 marks a load.
- reg_write_m  in  1  Memory-stage register write enable.
- reg_write_w  in  1  Writeback-stage register write enable.
- pc_src_e  in  1  taken branch or jump resolved in Execute.
- dmem_req_m  in  1  load/store access active in Memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the F/D register.
- stall_e  out  1  hold the D/E register.
- stall_m  out  1  hold the E/M register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  clear the D/E register.
- flush_w  out  1  clear the M/W register (bubble into Writeback).
- forward_a_e  out  2  operand A select: 00 register file, 01 Writeback, 10 Memory.
- forward_b_e  out  2  operand B select, same encoding as forward_a_e.
- stall_cnt  out  CNT_WIDTH  cycles with stall_f asserted.
- flush_cnt  out  CNT_WIDTH  cycles with flush_d asserted by a branch.
- mem_timeout  out  1  sticky: a memory wait exceeded TIMEOUT cycles.

Behaviour:
- Registered state: fsm (RUN/MEM_WAIT), wait_cnt, stall_cnt, flush_cnt, mem_timeout.
- On reset (rst=0, asynchronous):
  - fsm=RUN.
  - wait_cnt, stall_cnt and flush_cnt = 0.
  - mem_timeout = 0.
- All other outputs are combinational in the current inputs and registered state; there are no registered outputs. With fsm=RUN and all inputs 0, every output is 0.
- freeze = dmem_req_m & ~dmem_ready & (fsm==RUN), or ~dmem_ready & (fsm==MEM_WAIT).
- FSM transitions:
  - RUN -> MEM_WAIT when dmem_req_m & ~dmem_ready.
  - MEM_WAIT -> RUN when dmem_ready.
  - Release is zero-latency: freeze drops in the same cycle dmem_ready rises.
- While freeze is asserted:
  - stall_f, stall_d, stall_e, stall_m = 1 and flush_w = 1.
  - flush_d = flush_e = 0; freeze overrides the load-use and branch logic.
- load_use = (result_src_e==01) & (rd_e!=0) & ((rd_e==rs1_d) | (rd_e==rs2_d)).
- When not frozen and load_use is asserted: stall_f = stall_d = 1 and flush_e = 1. Latency 1 bubble.
- When not frozen and pc_src_e is asserted: flush_d = flush_e = 1.
- When load_use and pc_src_e occur together, the branch wins:
  - flush_d = flush_e = 1.
  - stall_f = stall_d = 0, because the younger instructions are discarded.
- pc_src_e arriving during freeze: Execute is held, so pc_src_e persists and the flush issues on the release cycle.
- Forwarding for operand A (B identical using rs2_e):
  - 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e.
  - else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e.
  - else 00.
  - Memory has priority over Writeback.
  - Forwarding is evaluated even during freeze.
- wait_cnt:
  - Increments each cycle in MEM_WAIT; saturates at TIMEOUT.
  - Clears on return to RUN.
  - mem_timeout is set when wait_cnt reaches TIMEOUT-1 and is cleared only by reset.
  - The pipeline keeps waiting after timeout; there is no abort.
- Counters:
  - stall_cnt += 1 on each cycle with stall_f.
  - flush_cnt += 1 on each cycle with branch-induced flush_d.
  - Both saturate at all-ones.
- Reset mid-wait: fsm returns to RUN and all stalls deassert immediately.

Decomposition:
- Package hazard_pkg:
  - fsm_t enum {RUN, MEM_WAIT}.
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RES_SRC_LOAD=2'b01.
- Sub-module fwd_sel: combinational priority selector for one operand, instantiated twice (A, B).

Test Plan:
- lw x5 in Execute (result_src_e=01, rd_e=5), rs1_d=5 -> for one cycle stall_f=stall_d=flush_e=1; stall_cnt increments by 1.
- reg_write_m=1, rd_m=3, reg_write_w=1, rd_w=3, rs1_e=3, rs2_e=0 -> forward_a_e=10, forward_b_e=00.
- rd_m=0, reg_write_m=1, rs1_e=0 -> forward_a_e=00 (x0 never forwarded).
- dmem_req_m=1 with dmem_ready low for 4 cycles, then high:
  - all four stalls and flush_w are high for exactly 4 cycles; fsm returns to RUN on the 5th.
  - pc_src_e=1 held through the wait gives flush_d=flush_e=1 only on the release cycle; flush_cnt increments by 1.
- TIMEOUT=8, dmem_ready low for 10 cycles -> mem_timeout rises after the 8th wait cycle and stays 1 after release until rst=0.
- load_use and pc_src_e together -> flush_d=flush_e=1, stall_f=0. Assert rst=0 in MEM_WAIT -> all outputs 0 asynchronously and counters cleared.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } fsm_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - operand forwarding priority selector, Memory stage over Writeback
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        fwd
);

  // x0 is hardwired to zero, so a write to it is never forwarded.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_p.sv
// rtl/hazard_ctrl_p.sv - stall/flush/forward control and data-memory wait sequencing
module hazard_ctrl_p
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 256,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rs1_d,
  input  logic [ADDR_W-1:0]    rs2_d,
  input  logic [ADDR_W-1:0]    rs1_e,
  input  logic [ADDR_W-1:0]    rs2_e,
  input  logic [ADDR_W-1:0]    rd_e,
  input  logic [ADDR_W-1:0]    rd_m,
  input  logic [ADDR_W-1:0]    rd_w,
  input  logic [1:0]           result_src_e,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  input  logic                 pc_src_e,
  input  logic                 dmem_req_m,
  input  logic                 dmem_ready,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 stall_e,
  output logic                 stall_m,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_w,
  output logic [1:0]           forward_a_e,
  output logic [1:0]           forward_b_e,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  fsm_t            state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            freeze;
  logic            load_use;
  logic            branch_flush;
  logic            timeout_hit;
  logic [1:0]      fwd_a, fwd_b;

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_a)
  );

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (branch_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Everything is held low while reset is asserted, even with a request pending.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    freeze       = 1'b0;
    timeout_hit  = 1'b0;
    load_use     = 1'b0;
    branch_flush = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    forward_a_e  = FWD_RF;
    forward_b_e  = FWD_RF;

    if (rst) begin
      case (state)
        RUN: begin
          if (dmem_req_m && !dmem_ready) begin
            freeze    = 1'b1;
            state_nxt = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_nxt = RUN;
          end else begin
            freeze       = 1'b1;
            wait_cnt_nxt = (wait_cnt == WC_W'(TIMEOUT)) ? wait_cnt : wait_cnt + WC_W'(1);
            timeout_hit  = (wait_cnt == WC_W'(TIMEOUT - 1));
          end
        end
        default: state_nxt = RUN;
      endcase

      load_use = (result_src_e == RES_SRC_LOAD) && (rd_e != '0) &&
                 ((rd_e == rs1_d) || (rd_e == rs2_d));
      branch_flush = pc_src_e && !freeze;

      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        // Younger instructions are discarded, so a coincident load-use stall is moot.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end

      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// tb/tb_hazard_ctrl_p.sv - randomized self-checking bench against a rule-level reference model
module tb_hazard_ctrl_p;

  localparam int CW = 6;
  localparam int TO = 8;
  localparam int AW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]    result_src_e;
  logic          reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0]    forward_a_e, forward_b_e;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          mem_timeout;

  hazard_ctrl_p #(.CNT_WIDTH(CW), .TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .result_src_e (result_src_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .dmem_req_m   (dmem_req_m),
    .dmem_ready   (dmem_ready),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .mem_timeout  (mem_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: is a memory wait outstanding, how long it has lasted, counters, flag.
  bit m_wait;
  int m_len;
  int m_scnt;
  int m_fcnt;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] ctl_vec();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  task automatic model_reset();
    m_wait = 0;
    m_len  = 0;
    m_scnt = 0;
    m_fcnt = 0;
    m_to   = 0;
  endtask

  task automatic clr_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    result_src_e = 2'b00;
    {reg_write_m, reg_write_w, pc_src_e, dmem_req_m, dmem_ready} = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model past the rising edge.
  task automatic step();
    bit frz, lu, stl, br, fe;
    @(negedge clk);
    frz = (dmem_req_m && !dmem_ready && !m_wait) || (m_wait && !dmem_ready);
    lu  = (result_src_e == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
    stl = frz || (lu && !pc_src_e);
    br  = pc_src_e && !frz;
    fe  = !frz && (pc_src_e || lu);
    check_eq("ctrl", 32'(ctl_vec()), 32'({stl, stl, frz, frz, br, fe, frz}));
    check_eq("fwd_a", 32'(forward_a_e), 32'(fwd_ref(rs1_e)));
    check_eq("fwd_b", 32'(forward_b_e), 32'(fwd_ref(rs2_e)));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    check_eq("mem_timeout", 32'(mem_timeout), 32'(m_to));
    @(posedge clk);
    #1;
    if (stl && m_scnt < CMAX) m_scnt++;
    if (br && m_fcnt < CMAX) m_fcnt++;
    m_len = frz ? m_len + 1 : 0;
    if (frz && m_len > TO) m_to = 1;
    m_wait = frz;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b1;
  endtask

  int hold_low;

  initial begin
    model_reset();
    do_reset();

    // Reset state with idle inputs.
    #2;
    check_eq("reset_all_zero",
             {8'h0, ctl_vec(), forward_a_e, forward_b_e, stall_cnt, flush_cnt, mem_timeout}, 32'h0);
    step();

    // Load-use bubble.
    result_src_e = 2'b01; rd_e = 5; rs1_d = 5;
    #2;
    check_eq("lu_stall", 32'({stall_f, stall_d, flush_e, flush_d}), 32'b1110);
    step();
    clr_inputs();
    #2;
    check_eq("lu_cnt", 32'(stall_cnt), 32'd1);
    step();

    // Memory forwarding beats Writeback; x0 is never forwarded.
    reg_write_m = 1; rd_m = 3; reg_write_w = 1; rd_w = 3; rs1_e = 3; rs2_e = 0;
    #2;
    check_eq("fwd_mem_pri", 32'({forward_a_e, forward_b_e}), 32'b1000);
    step();
    rd_m = 0; rs1_e = 0; reg_write_w = 0;
    #2;
    check_eq("fwd_x0", 32'(forward_a_e), 32'b00);
    step();

    // Four-cycle memory wait with a branch held through it.
    do_reset();
    dmem_req_m = 1; dmem_ready = 0; pc_src_e = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq("wait_frozen", 32'(ctl_vec()), 32'b1111001);
      step();
    end
    dmem_ready = 1;
    #2;
    check_eq("wait_release", 32'(ctl_vec()), 32'b0000110);
    step();
    clr_inputs();
    #2;
    check_eq("wait_flush_cnt", 32'(flush_cnt), 32'd1);
    check_eq("wait_stall_cnt", 32'(stall_cnt), 32'd4);
    step();

    // Timeout: ten cycles of not-ready.
    do_reset();
    dmem_req_m = 1; dmem_ready = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (i == 8) check_eq("to_before", 32'(mem_timeout), 32'd0);
      if (i == 9) check_eq("to_after", 32'(mem_timeout), 32'd1);
      step();
    end
    dmem_ready = 1;
    step();
    clr_inputs();
    #2;
    check_eq("to_sticky", 32'(mem_timeout), 32'd1);
    step();

    // Branch wins over a coincident load-use.
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7; pc_src_e = 1;
    #2;
    check_eq("br_over_lu", 32'({stall_f, flush_d, flush_e}), 32'b011);
    step();

    // Asynchronous reset in the middle of a wait.
    clr_inputs();
    dmem_req_m = 1; dmem_ready = 0; reg_write_m = 1; rd_m = 3; rs1_e = 3;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("async_rst",
             {8'h0, ctl_vec(), forward_a_e, forward_b_e, stall_cnt, flush_cnt, mem_timeout}, 32'h0);
    do_reset();

    // Randomized traffic with periodic resets.
    hold_low = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) do_reset();
      rs1_d = AW'($urandom_range(0, 3));
      rs2_d = AW'($urandom_range(0, 3));
      rs1_e = AW'($urandom_range(0, 3));
      rs2_e = AW'($urandom_range(0, 3));
      rd_e  = AW'($urandom_range(0, 3));
      rd_m  = AW'($urandom_range(0, 3));
      rd_w  = AW'($urandom_range(0, 3));
      result_src_e = 2'($urandom_range(0, 3));
      reg_write_m  = 1'($urandom);
      reg_write_w  = 1'($urandom);
      pc_src_e     = ($urandom_range(0, 5) == 0);
      dmem_req_m   = ($urandom_range(0, 2) == 0);
      if (hold_low > 0) begin
        dmem_ready = 0;
        hold_low--;
      end else if ($urandom_range(0, 19) == 0) begin
        hold_low = $urandom_range(5, 12);
        dmem_ready = 0;
      end else begin
        dmem_ready = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
